// File: rtl/proc_ram_arb_pkg.sv
// Shared state encoding and default widths for the processor data-RAM arbiter.
package proc_ram_arb_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/proc_ram_arbiter_pick.sv
// proc_rr_pick: two-way winner pick; on a tie the port not served last wins.
module proc_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        if (req[0] && req[1]) begin
            // last = 1 means port 1 was served most recently, so port 0 goes next
            pick = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            pick = 2'b01;
        end else if (req[1]) begin
            pick = 2'b10;
        end
    end

endmodule

// File: rtl/proc_ram_arbiter.sv
// proc_ram_arbiter: arbitrates processor and host ports onto one synchronous data RAM.
// Define PROC_RAM_ARB_FIXED_PRI_EN to make port 0 win every tie instead of round-robin.
module proc_ram_arbiter
    import proc_ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_re,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [1:0]        pick;
    logic              sel1;
    logic              take;
    logic              last_srv;
    logic              win_p0;
    logic              we_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    assign take = (state == IDLE) && (req0 || req1);
    assign sel1 = pick[1] && !pick[0];

`ifdef PROC_RAM_ARB_FIXED_PRI_EN
    assign last_srv = 1'b1;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_srv <= 1'b1;
        end else if (take) begin
            last_srv <= sel1;
        end
    end
`endif

    proc_rr_pick u_pick (
        .req  ({req1, req0}),
        .last (last_srv),
        .pick (pick)
    );

    // IDLE -> ACCESS boundary: capture the winner and its operands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            win_p0 <= 1'b0;
            we_p0  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                win_p0 <= sel1;
                we_p0  <= sel1 ? we1 : we0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            addr_p0  <= sel1 ? addr1 : addr0;
            wdata_p0 <= sel1 ? wdata1 : wdata0;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = we_p0 ? IDLE : RESP;
                gnt0      = !win_p0;
                gnt1      = win_p0;
                ram_we    = we_p0;
                ram_re    = !we_p0;
                ram_addr  = addr_p0;
                ram_din   = wdata_p0;
            end
            RESP: begin
                // RAM read data arrives one cycle after ram_re
                state_nxt = IDLE;
                rvalid0   = !win_p0;
                rvalid1   = win_p0;
                rdata0    = win_p0 ? '0 : ram_dout;
                rdata1    = win_p0 ? ram_dout : '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
